adder_share_sched: RTL and testbench
====================================

// Module: adder_share_sched
// PURPOSE
//  Schedules one shared multicycle ripple-carry adder (rippleadder) among NREQ
//  requesters, e.g. mesh router ports computing address/credit arithmetic.
//  - Round-robin arbitration, valid/ready on both request and response sides.
//  - One operation in flight at a time.
//  - Operands are held stable for SETTLE cycles so the ripple chain is a
//    declared multicycle path.
// PARAMETERS
//  WIDTH   4  operand/sum width; >=2 (rippleadder minimum)
//  NREQ    4  number of requesters; >=2
//  SETTLE  2  cycles operands are held before the sum is sampled; >=1
// PORTS
//  clk        in   1            system clock, rising edge
//  reset      in   1            asynchronous, active-high reset
//  req_valid  in   NREQ         requester i has an operation pending
//  req_ready  out  NREQ         one-hot grant; transfer when valid&ready
//  req_a      in   NREQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH   operand B, same packing as req_a
//  req_cin    in   NREQ         carry-in per requester
//  resp_valid out  1            result available
//  resp_ready in   1            consumer accepts result
//  resp_id    out  $clog2(NREQ) index of the requester that owns the result
//  resp_sum   out  WIDTH        (A+B+Cin) mod 2^WIDTH
//  resp_cout  out  1            carry out of bit WIDTH-1
//  busy       out  1            high in every state except IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, rr_ptr=0, settle counter=0, operand
//   regs=0. Outputs: req_ready=0, resp_valid=0, resp_id=0, resp_sum=0,
//   resp_cout=0, busy=0. An in-flight op is discarded; no response is produced.
//  FSM states: IDLE, EVAL, RESP.
//  IDLE
//   - grant = first i with req_valid[i], searching from rr_ptr upward and
//     wrapping at NREQ-1 -> 0.
//   - req_ready = onehot(grant), combinational from req_valid and rr_ptr;
//     all zero if no valid.
//   - On the handshake edge: latch req_a/req_b/req_cin[grant] and id=grant;
//     rr_ptr <= (grant+1) mod NREQ; counter <= SETTLE-1; go to EVAL.
//  EVAL
//   - req_ready=0; registered operands drive rippleadder.
//   - If counter!=0: counter--.
//   - Else: resp_sum <= Sum, resp_cout <= Cout, resp_id <= id, resp_valid <= 1;
//     go to RESP.
//  RESP
//   - req_ready=0; resp_* held stable until resp_ready.
//   - On resp_valid&resp_ready: resp_valid <= 0; go to IDLE. The next grant is
//     possible on the following cycle.
//  Latency: resp_valid rises exactly SETTLE cycles after the accept edge.
//   Minimum issue interval is SETTLE+2 cycles.
//  Requester rules
//   - A requester may drop req_valid before it is granted; no state is kept.
//   - A requester is never granted twice in a row while another requester is
//     valid.
//  Overflow: the sum wraps mod 2^WIDTH, with carry reported only on resp_cout.
//  resp_ready high while in IDLE/EVAL: ignored.
// STRUCTURE
//  Package adder_sched_pkg: typedef enum logic[1:0] {IDLE,EVAL,RESP} state_t;
//   function rr_pick(valid, ptr) returning the grant index.
//  Sub-module rr_arbiter #(NREQ) (valid, ptr -> onehot grant, index):
//   combinational, reusable by router allocators.
//  Datapath: one existing rippleadder #(WIDTH) instance fed only from
//   registered operands; no other arithmetic in the block.
// TESTING
//  1 WIDTH=4, SETTLE=2, req0 A=3 B=4 Cin=0 -> req_ready=0001 once;
//    2 cycles later resp_valid=1, sum=7, cout=0, id=0.
//  2 Overflow: A=F B=1 Cin=1 -> sum=1, cout=1; A=F B=F Cin=1 -> sum=F, cout=1.
//  3 All four valid continuously, resp_ready=1 -> grants in order
//    0,1,2,3,0; each grant exactly SETTLE+2 cycles apart.
//  4 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable,
//    req_ready=0000; on release, the next grant comes 1 cycle later.
//  5 Reset pulsed mid-EVAL -> all outputs 0 immediately (async); no stale
//    resp_valid after release; rr_ptr=0.
//  6 Random stimulus, SETTLE=1 and SETTLE=3 -> every result matches the
//    scoreboard (A+B+Cin), ids match grants, no requester starved for more than
//    NREQ grants.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the shared-adder scheduler and its arbiter.
package adder_sched_pkg;

  // Controller states: waiting for a request, letting the ripple chain
  // settle, and holding a result for the consumer.
  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  // Widest request vector rr_pick can search; callers zero-extend into it.
  localparam int MAX_REQ = 64;

  // Round-robin pick: first set bit of valid[nreq-1:0], starting at ptr and
  // wrapping from nreq-1 back to 0. Returns -1 when nothing is valid.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                 input int                 ptr,
                                 input int                 nreq);
    int pick;
    int j;
    pick = -1;
    // Walk the search order backwards so the earliest candidate wins last,
    // which avoids an early exit from the loop.
    for (int k = nreq - 1; k >= 0; k--) begin
      j = ptr + k;
      if (j >= nreq) j = j - nreq;
      if (valid[j]) pick = j;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rippleadder.sv
// Plain ripple-carry adder; the carry chain is the multicycle path the
// scheduler waits out before sampling the sum.
module rippleadder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester at or
// after ptr (wrapping) and reports it as a one-hot grant plus an index.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [MAX_REQ-1:0] valid_ext;
  int                 pick;

  // Grant decode from the round-robin search.
  always_comb begin
    // NOTE: every output gets a default before the conditional update, so no
    // path leaves a value unassigned and no latch is inferred.
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    pick                  = rr_pick(valid_ext, int'(ptr), NREQ);
    grant                 = '0;
    idx                   = '0;
    any                   = 1'b0;
    if (pick >= 0) begin
      any         = 1'b1;
      idx         = IDW'(pick);
      grant[pick] = 1'b1;
    end
  end

endmodule

// File: rtl/adder_share_sched.sv
// Schedules one shared multicycle ripple-carry adder among NREQ requesters.
// Round-robin grant in IDLE, operands held for SETTLE cycles in EVAL, result
// held in RESP until the consumer takes it. One operation in flight at most.
module adder_share_sched
  import adder_sched_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int NREQ   = 4,
  parameter  int SETTLE = 2,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_cout,
  output logic                  busy
);

  // Settle counter counts SETTLE-1 down to 0, so it needs enough bits for
  // SETTLE-1 and at least one bit when SETTLE is 1.
  localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              op_cin;
  logic [IDW-1:0]    op_id;

  logic [NREQ-1:0]   arb_grant;
  logic [IDW-1:0]    arb_idx;
  logic              arb_any;
  logic              accept;
  logic [IDW-1:0]    next_ptr;
  logic [WIDTH-1:0]  add_sum;
  logic              add_cout;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // The adder only ever sees registered operands, which stay put for the
  // whole EVAL window so the carry chain can be timed as a multicycle path.
  rippleadder #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Grants are offered only while idle and out of reset; a grant with a
  // matching valid is the handshake.
  assign req_ready = (state == IDLE && !reset) ? arb_grant : '0;
  assign accept    = (state == IDLE) && !reset && arb_any;
  assign next_ptr  = (arb_idx == LAST_ID) ? '0 : arb_idx + IDW'(1);
  assign busy      = (state != IDLE);

  // Controller: accept, wait out the ripple chain, hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      // NOTE: the operand registers are cleared too, so the adder never
      // propagates unknowns after reset and a discarded op leaves no trace.
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from the values present before the edge.
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= req_a[arb_idx*WIDTH +: WIDTH];
            op_b   <= req_b[arb_idx*WIDTH +: WIDTH];
            op_cin <= req_cin[arb_idx];
            op_id  <= arb_idx;
            rr_ptr <= next_ptr;
            cnt    <= CNT_LOAD;
            state  <= EVAL;
          end
        end
        EVAL: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            resp_sum   <= add_sum;
            resp_cout  <= add_cout;
            resp_id    <= op_id;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: three instances (SETTLE=2 directed, SETTLE=1
// and SETTLE=3 random), each watched by a cycle-level behavioural model.
module tb_adder_share_sched;

  localparam int W           = 4;
  localparam int N           = 4;
  localparam int IW          = 2;
  localparam int AW          = N * W;
  localparam int NINST       = 3;
  localparam int RAND_CYCLES = 3000;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester at or after p, wrapping.
  function automatic int rr_expect(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : 3;

    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [AW-1:0] req_a;
    logic [AW-1:0] req_b;
    logic [N-1:0]  req_cin;
    logic          resp_valid;
    logic          resp_ready;
    logic [IW-1:0] resp_id;
    logic [W-1:0]  resp_sum;
    logic          resp_cout;
    logic          busy;

    adder_share_sched #(
      .WIDTH  (W),
      .NREQ   (N),
      .SETTLE (ST)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_cin    (req_cin),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .busy       (busy)
    );

    // Model: the block is either free, or owns one op whose result appears
    // ST+1 negedges after the negedge that saw the handshake, and stays
    // until a negedge sees resp_ready.
    initial begin : model
      bit    idle;
      bit    rv;
      int    ptr, cyc, due, pick, tot, exp_rdy;
      int    pid, psum, pcout, eid, esum, ecout;
      int    starve [N];
      string tag;
      idle = 1'b1; rv = 1'b0; ptr = 0; cyc = 0; due = 0;
      pid = 0; psum = 0; pcout = 0; eid = 0; esum = 0; ecout = 0;
      foreach (starve[i]) starve[i] = 0;
      tag = $sformatf("settle%0d", ST);
      forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
          idle = 1'b1; rv = 1'b0; ptr = 0;
          eid = 0; esum = 0; ecout = 0;
          foreach (starve[i]) starve[i] = 0;
          check({tag, " reset req_ready"},  int'(req_ready),  0);
          check({tag, " reset resp_valid"}, int'(resp_valid), 0);
          check({tag, " reset busy"},       int'(busy),       0);
          check({tag, " reset resp_sum"},   int'(resp_sum),   0);
          check({tag, " reset resp_id"},    int'(resp_id),    0);
          check({tag, " reset resp_cout"},  int'(resp_cout),  0);
        end else begin
          if (!idle && !rv && cyc == due) begin
            rv = 1'b1; eid = pid; esum = psum; ecout = pcout;
          end
          pick    = rr_expect(req_valid, ptr);
          exp_rdy = (idle && pick >= 0) ? (1 << pick) : 0;
          check({tag, " req_ready"},  int'(req_ready),  exp_rdy);
          check({tag, " busy"},       int'(busy),       int'(!idle));
          check({tag, " resp_valid"}, int'(resp_valid), int'(rv));
          check({tag, " resp_sum"},   int'(resp_sum),   esum);
          check({tag, " resp_id"},    int'(resp_id),    eid);
          check({tag, " resp_cout"},  int'(resp_cout),  ecout);
          for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) starve[i] = 0;
          end
          if (rv && resp_ready) begin
            rv   = 1'b0;
            idle = 1'b1;
          end else if (idle && pick >= 0) begin
            tot   = int'(req_a[pick*W +: W]) + int'(req_b[pick*W +: W]) + int'(req_cin[pick]);
            psum  = tot % (1 << W);
            pcout = tot / (1 << W);
            pid   = pick;
            ptr   = (pick + 1) % N;
            idle  = 1'b0;
            due   = cyc + ST + 1;
            for (int i = 0; i < N; i++) begin
              if (i == pick) begin
                starve[i] = 0;
              end else if (req_valid[i]) begin
                starve[i]++;
                check($sformatf("%s starvation req%0d", tag, i), int'(starve[i] < N), 1);
              end
            end
          end
        end
      end
    end

    if (g != 0) begin : g_rand
      logic done;
      initial begin
        done       = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = 1'b0;
        @(negedge reset);
        repeat (RAND_CYCLES) begin
          @(posedge clk);
          #1;
          for (int i = 0; i < N; i++) begin
            req_valid[i] = req_valid[i] ? ($urandom_range(0, 7) != 0)
                                        : ($urandom_range(0, 2) == 0);
          end
          req_a      = AW'($urandom);
          req_b      = AW'($urandom);
          req_cin    = N'($urandom);
          resp_ready = ($urandom_range(0, 3) != 0);
        end
        done = 1'b1;
      end
    end
  end

  task automatic set_op(input int r, input int a, input int b, input int cin);
    g_inst[0].req_a[r*W +: W] = W'(a);
    g_inst[0].req_b[r*W +: W] = W'(b);
    g_inst[0].req_cin[r]      = cin[0];
    g_inst[0].req_valid[r]    = 1'b1;
  endtask

  // One op from requester r on the SETTLE=2 instance with literal results.
  task automatic run_op(input string nm, input int r, input int a, input int b,
                        input int cin, input int exp_sum, input int exp_cout);
    @(posedge clk);
    #1;
    g_inst[0].resp_ready = 1'b1;
    set_op(r, a, b, cin);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (g_inst[0].req_ready != '0) break;
    end
    check({nm, " grant"}, int'(g_inst[0].req_ready), 1 << r);
    @(posedge clk);
    #1;
    g_inst[0].req_valid = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (g_inst[0].resp_valid) break;
    end
    check({nm, " resp_valid"}, int'(g_inst[0].resp_valid), 1);
    check({nm, " sum"},        int'(g_inst[0].resp_sum),   exp_sum);
    check({nm, " cout"},       int'(g_inst[0].resp_cout),  exp_cout);
    check({nm, " id"},         int'(g_inst[0].resp_id),    r);
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!g_inst[0].busy) break;
    end
    check({nm, " idle"}, int'(g_inst[0].busy), 0);
  endtask

  initial begin
    int gid  [5];
    int gcyc [5];
    int n, t;

    reset                = 1'b1;
    g_inst[0].req_valid  = '0;
    g_inst[0].req_a      = '0;
    g_inst[0].req_b      = '0;
    g_inst[0].req_cin    = '0;
    g_inst[0].resp_ready = 1'b0;

    @(negedge clk);
    check("reset state resp_valid", int'(g_inst[0].resp_valid), 0);
    check("reset state busy",       int'(g_inst[0].busy),       0);
    @(posedge clk);
    #3 reset = 1'b0;

    // Basic op: requester 0, 3+4.
    @(posedge clk);
    #1;
    g_inst[0].resp_ready = 1'b1;
    set_op(0, 3, 4, 0);
    @(negedge clk);
    check("basic grant", int'(g_inst[0].req_ready), 4'b0001);
    @(posedge clk);
    #1 g_inst[0].req_valid = '0;
    @(negedge clk);
    check("basic ready dropped", int'(g_inst[0].req_ready),  0);
    check("basic early valid 1", int'(g_inst[0].resp_valid), 0);
    @(negedge clk);
    check("basic early valid 2", int'(g_inst[0].resp_valid), 0);
    @(negedge clk);
    check("basic resp_valid", int'(g_inst[0].resp_valid), 1);
    check("basic sum",        int'(g_inst[0].resp_sum),   7);
    check("basic cout",       int'(g_inst[0].resp_cout),  0);
    check("basic id",         int'(g_inst[0].resp_id),    0);

    // Overflow wraps with the carry reported separately.
    run_op("ovf f+1+1", 0, 4'hf, 4'h1, 1, 4'h1, 1);
    run_op("ovf f+f+1", 0, 4'hf, 4'hf, 1, 4'hf, 1);
    run_op("req2 5+6+1", 2, 4'h5, 4'h6, 1, 4'hc, 0);

    // Reset in the middle of EVAL discards the op.
    @(posedge clk);
    #1 set_op(1, 6, 9, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (g_inst[0].req_ready != '0) break;
    end
    check("midreset grant", int'(g_inst[0].req_ready), 4'b0010);
    @(posedge clk);
    #1 g_inst[0].req_valid = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midreset resp_valid", int'(g_inst[0].resp_valid), 0);
    check("midreset busy",       int'(g_inst[0].busy),       0);
    check("midreset req_ready",  int'(g_inst[0].req_ready),  0);
    check("midreset sum",        int'(g_inst[0].resp_sum),   0);
    check("midreset id",         int'(g_inst[0].resp_id),    0);
    check("midreset cout",       int'(g_inst[0].resp_cout),  0);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midreset stale valid", int'(g_inst[0].resp_valid), 0);
    end

    // All four valid continuously: 0,1,2,3,0 at SETTLE+2 spacing.
    @(posedge clk);
    #1;
    g_inst[0].resp_ready = 1'b1;
    for (int r = 0; r < N; r++) set_op(r, r, r + 1, 0);
    n = 0;
    t = 0;
    while (n < 5 && t < 80) begin
      @(negedge clk);
      t++;
      if (g_inst[0].req_ready != '0) begin
        gid[n]  = onehot_idx(g_inst[0].req_ready);
        gcyc[n] = t;
        n++;
      end
    end
    check("rr grant count", n, 5);
    for (int k = 0; k < n; k++) begin
      check($sformatf("rr grant %0d id", k), gid[k], k % N);
      if (k > 0) check($sformatf("rr grant %0d spacing", k), gcyc[k] - gcyc[k-1], 4);
    end
    @(posedge clk);
    #1 g_inst[0].req_valid = '0;
    wait_idle("rr drain");

    // Backpressure: result held five cycles with others waiting.
    @(posedge clk);
    #1;
    g_inst[0].resp_ready = 1'b0;
    set_op(2, 7, 7, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (g_inst[0].req_ready != '0) break;
    end
    check("bp grant", int'(g_inst[0].req_ready), 4'b0100);
    @(posedge clk);
    #1;
    g_inst[0].req_valid = 4'b1011;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (g_inst[0].resp_valid) break;
    end
    check("bp resp_valid", int'(g_inst[0].resp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp hold valid", int'(g_inst[0].resp_valid), 1);
      check("bp hold sum",   int'(g_inst[0].resp_sum),   4'hf);
      check("bp hold cout",  int'(g_inst[0].resp_cout),  0);
      check("bp hold id",    int'(g_inst[0].resp_id),    2);
      check("bp hold ready", int'(g_inst[0].req_ready),  0);
    end
    @(posedge clk);
    #1 g_inst[0].resp_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", int'(g_inst[0].resp_valid), 1);
    @(negedge clk);
    check("bp after valid", int'(g_inst[0].resp_valid), 0);
    check("bp next grant",  int'(g_inst[0].req_ready),  4'b1000);
    @(posedge clk);
    #1 g_inst[0].req_valid = '0;
    wait_idle("bp drain");

    wait (g_inst[1].g_rand.done && g_inst[2].g_rand.done);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
